d_drain_arbiter: RTL and testbench

- Downstream stage of the full-logic block. It drains the D0 and D1 destination FIFOs through their pop/empty interface.
- Arbitrates between the two FIFOs round-robin and emits one word per cycle toward the sink, subject to the sink's almost-full back-pressure.
- Keeps a per-destination count of words emitted. The count can be read back while the link FSM reports idle.

---
 rtl/d_drain_arbiter_pkg.sv | 20 ++
 rtl/d_drain_arbiter_rr_arbiter_2.sv | 50 +++++
 rtl/d_drain_arbiter.sv | 122 ++++++++++++
 tb/tb_d_drain_arbiter.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/d_drain_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : d_drain_arbiter_pkg
// Description : Shared widths and channel-select type for the D0/D1 drain
//               path. The full-logic demux uses the same channel type.
// Revision    : 1.0 - initial release
// ============================================================================
package d_drain_arbiter_pkg;

    localparam int DATA_WIDTH  = 6;
    localparam int COUNT_WIDTH = 5;

    // Channel select. The demux upstream and this arbiter agree on the encoding.
    typedef enum logic {
        CH_D0 = 1'b0,
        CH_D1 = 1'b1
    } ch_sel_t;

endpackage
`default_nettype wire

// File: rtl/d_drain_arbiter_rr_arbiter_2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter_2
// Description : Two-way round-robin pop arbiter. Pops are combinational from
//               the empty flags, the sink back-pressure and the registered
//               last grant. Only one FIFO is popped per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter_2
    import d_drain_arbiter_pkg::*;
(
    input  logic    clk,
    input  logic    reset,
    input  logic    i_empty_d0,
    input  logic    i_empty_d1,
    input  logic    i_sink_almost_full,
    output logic    o_pop_d0,
    output logic    o_pop_d1,
    output ch_sel_t o_grant_ch
);

    ch_sel_t r_last_grant;
    logic    w_can_d0;
    logic    w_can_d1;
    logic    w_pick_d0;
    logic    w_pick_d1;

    // A channel is eligible when it holds data and the sink has slack; D0 wins
    // ties unless it was the last channel served. Pops are held low in reset.
    always_comb begin
        w_can_d0   = reset & ~i_sink_almost_full & ~i_empty_d0;
        w_can_d1   = reset & ~i_sink_almost_full & ~i_empty_d1;
        w_pick_d0  = w_can_d0 & (~w_can_d1 | (r_last_grant == CH_D1));
        w_pick_d1  = w_can_d1 & ~w_pick_d0;
        o_pop_d0   = w_pick_d0;
        o_pop_d1   = w_pick_d1;
        o_grant_ch = w_pick_d1 ? CH_D1 : CH_D0;
    end

    // Remember the channel served; unchanged on cycles without a pop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_last_grant <= CH_D1;
        end else if (w_pick_d0 || w_pick_d1) begin
            r_last_grant <= o_grant_ch;
        end
    end

endmodule
`default_nettype wire

// File: rtl/d_drain_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : d_drain_arbiter
// Description : Drains the D0/D1 destination FIFOs round-robin toward the
//               sink, one word per cycle, two cycles from pop to valid_out.
//               Keeps a wrapping per-channel word count readable while idle.
// Revision    : 1.0 - initial release
// ============================================================================
module d_drain_arbiter #(
    parameter int DATA_WIDTH  = d_drain_arbiter_pkg::DATA_WIDTH,
    parameter int COUNT_WIDTH = d_drain_arbiter_pkg::COUNT_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   empty_fifo_D0,
    input  logic                   empty_fifo_D1,
    input  logic [DATA_WIDTH-1:0]  data_out_D0,
    input  logic [DATA_WIDTH-1:0]  data_out_D1,
    input  logic                   sink_almost_full,
    input  logic                   idle_in,
    input  logic                   req,
    input  logic                   idx,
    output logic                   D0_pop,
    output logic                   D1_pop,
    output logic [DATA_WIDTH-1:0]  data_out,
    output logic                   valid_out,
    output logic [COUNT_WIDTH-1:0] contador_out,
    output logic                   valid_contador
);

    import d_drain_arbiter_pkg::*;

    localparam logic [COUNT_WIDTH-1:0] c_count_one = COUNT_WIDTH'(1);

    logic                   w_pop_d0;
    logic                   w_pop_d1;
    ch_sel_t                w_grant_ch;

    ch_sel_t                r_sel;
    logic                   r_pend;
    ch_sel_t                r_src;
    logic [DATA_WIDTH-1:0]  r_data;
    logic                   r_valid;
    logic [COUNT_WIDTH-1:0] r_count_d0;
    logic [COUNT_WIDTH-1:0] r_count_d1;
    logic [COUNT_WIDTH-1:0] r_contador;
    logic                   r_valid_contador;

    rr_arbiter_2 u_rr_arbiter_2 (
        .clk                (clk),
        .reset              (reset),
        .i_empty_d0         (empty_fifo_D0),
        .i_empty_d1         (empty_fifo_D1),
        .i_sink_almost_full (sink_almost_full),
        .o_pop_d0           (w_pop_d0),
        .o_pop_d1           (w_pop_d1),
        .o_grant_ch         (w_grant_ch)
    );

    assign D0_pop         = w_pop_d0;
    assign D1_pop         = w_pop_d1;
    assign data_out       = r_data;
    assign valid_out      = r_valid;
    assign contador_out   = r_contador;
    assign valid_contador = r_valid_contador;

    // Stage 1: note which FIFO was popped; its data shows up next cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pend <= 1'b0;
            r_sel  <= CH_D0;
        end else begin
            r_pend <= w_pop_d0 | w_pop_d1;
            r_sel  <= w_grant_ch;
        end
    end

    // Stage 2: capture the FIFO read data of the pending pop into the output.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_src   <= CH_D0;
        end else begin
            r_valid <= r_pend;
            if (r_pend) begin
                r_data <= (r_sel == CH_D1) ? data_out_D1 : data_out_D0;
                r_src  <= r_sel;
            end
        end
    end

    // Count each emitted word against its source channel; wraps naturally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count_d0 <= '0;
            r_count_d1 <= '0;
        end else if (r_valid) begin
            if (r_src == CH_D1) begin
                r_count_d1 <= r_count_d1 + c_count_one;
            end else begin
                r_count_d0 <= r_count_d0 + c_count_one;
            end
        end
    end

    // Counter read-back, only while the link is idle; returns the value
    // before any increment happening in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_contador       <= '0;
            r_valid_contador <= 1'b0;
        end else begin
            r_valid_contador <= req & idle_in;
            if (req && idle_in) begin
                r_contador <= idx ? r_count_d1 : r_count_d0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_d_drain_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_d_drain_arbiter
// Description : Self-checking bench for d_drain_arbiter. Two FIFO models feed
//               the DUT; a queue-based reference model predicts pops, the
//               emitted word stream and the counter read-back.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_d_drain_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       sink_almost_full;
    logic       idle_in;
    logic       req;
    logic       idx;
    logic       empty0;
    logic       empty1;
    logic [5:0] fd0 = '0;
    logic [5:0] fd1 = '0;
    logic       D0_pop;
    logic       D1_pop;
    logic [5:0] data_out;
    logic       valid_out;
    logic [4:0] contador_out;
    logic       valid_contador;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    d_drain_arbiter dut (
        .clk              (clk),
        .reset            (reset),
        .empty_fifo_D0    (empty0),
        .empty_fifo_D1    (empty1),
        .data_out_D0      (fd0),
        .data_out_D1      (fd1),
        .sink_almost_full (sink_almost_full),
        .idle_in          (idle_in),
        .req              (req),
        .idx              (idx),
        .D0_pop           (D0_pop),
        .D1_pop           (D1_pop),
        .data_out         (data_out),
        .valid_out        (valid_out),
        .contador_out     (contador_out),
        .valid_contador   (valid_contador)
    );

    // ---------------- FIFO models (read data valid the cycle after a pop)
    logic [5:0] mem0 [4096];
    logic [5:0] mem1 [4096];
    int wr0 = 0, rd0 = 0, wr1 = 0, rd1 = 0;

    assign empty0 = (wr0 == rd0);
    assign empty1 = (wr1 == rd1);

    always @(posedge clk) begin
        if (D0_pop) begin
            fd0 <= mem0[rd0 % 4096];
            rd0 <= rd0 + 1;
        end
        if (D1_pop) begin
            fd1 <= mem1[rd1 % 4096];
            rd1 <= rd1 + 1;
        end
    end

    task automatic push0(input logic [5:0] w);
        mem0[wr0 % 4096] = w;
        wr0 = wr0 + 1;
    endtask

    task automatic push1(input logic [5:0] w);
        mem1[wr1 % 4096] = w;
        wr1 = wr1 + 1;
    endtask

    // ---------------- reference model
    typedef struct {
        int         due;
        logic       ch;
        logic [5:0] w;
    } fl_t;

    fl_t        inflight[$];
    int         cyc    = 0;
    logic       m_last = 1'b1;
    logic [4:0] m_cnt [2] = '{5'd0, 5'd0};
    logic [4:0] m_cont = '0;
    logic       m_vc   = 1'b0;

    // {pop_D1, pop_D0} expected from the round-robin rules in the current cycle.
    function automatic logic [1:0] model_grant();
        if (reset !== 1'b1 || sink_almost_full) return 2'b00;
        if (empty0 && empty1) return 2'b00;
        if (empty1) return 2'b01;
        if (empty0) return 2'b10;
        return (m_last == 1'b1) ? 2'b01 : 2'b10;
    endfunction

    initial begin : model
        logic [1:0] g;
        fl_t        item;
        forever begin
            @(posedge clk or negedge reset);
            if (reset !== 1'b1) begin
                inflight.delete();
                m_last   = 1'b1;
                m_cnt[0] = '0;
                m_cnt[1] = '0;
                m_cont   = '0;
                m_vc     = 1'b0;
            end else begin
                if (req && idle_in) begin
                    m_cont = m_cnt[idx];
                    m_vc   = 1'b1;
                end else begin
                    m_vc = 1'b0;
                end
                if (inflight.size() > 0 && inflight[0].due == cyc) begin
                    m_cnt[inflight[0].ch] = m_cnt[inflight[0].ch] + 5'd1;
                    void'(inflight.pop_front());
                end
                g = model_grant();
                if (g != 2'b00) begin
                    item.due = cyc + 2;
                    item.ch  = g[1];
                    item.w   = g[1] ? mem1[rd1 % 4096] : mem0[rd0 % 4096];
                    inflight.push_back(item);
                    m_last = g[1];
                end
                cyc = cyc + 1;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        sink_almost_full = 1'b0;
        req = 1'b0;
        idx = 1'b0;
        idle_in = 1'b0;
        #1;
        wr0 = rd0;
        wr1 = rd1;
        @(negedge clk);
        reset = 1'b1;
    endtask

    // ---------------- tests
    task automatic test_reset();
        push0(6'h11);
        push1(6'h2A);
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (D0_pop !== 1'b0 || D1_pop !== 1'b0) begin bad++; $display("FAIL rst_pops got=%b%b exp=00", D1_pop, D0_pop); end
            total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", valid_out); end
            total++; if (data_out !== 6'h00) begin bad++; $display("FAIL rst_data got=%h exp=00", data_out); end
            total++; if (contador_out !== 5'd0 || valid_contador !== 1'b0) begin bad++; $display("FAIL rst_cnt got=%0d/%b exp=0/0", contador_out, valid_contador); end
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        total++; if (D0_pop !== 1'b1 || D1_pop !== 1'b0) begin bad++; $display("FAIL rel_first_pop got=%b%b exp=01", D1_pop, D0_pop); end
        tick();
        total++; if (D1_pop !== 1'b1 || D0_pop !== 1'b0) begin bad++; $display("FAIL rel_second_pop got=%b%b exp=10", D1_pop, D0_pop); end
        tick();
        total++; if (valid_out !== 1'b1 || data_out !== 6'h11) begin bad++; $display("FAIL rel_word0 got=%b/%h exp=1/11", valid_out, data_out); end
        tick();
        total++; if (valid_out !== 1'b1 || data_out !== 6'h2A) begin bad++; $display("FAIL rel_word1 got=%b/%h exp=1/2a", valid_out, data_out); end
    endtask

    task automatic test_alternation();
        logic [1:0] exp_pop [4];
        logic [5:0] exp_dat [4];
        exp_pop = '{2'b01, 2'b10, 2'b01, 2'b10};
        exp_dat = '{6'h03, 6'h22, 6'h04, 6'h23};
        do_reset();
        push0(6'h03); push0(6'h04);
        push1(6'h22); push1(6'h23);
        #1;
        for (int i = 0; i < 7; i++) begin
            if (i > 0) tick();
            if (i < 4) begin
                total++; if ({D1_pop, D0_pop} !== exp_pop[i]) begin bad++; $display("FAIL alt_pop[%0d] got=%b%b exp=%b", i, D1_pop, D0_pop, exp_pop[i]); end
            end
            if (i >= 2 && i < 6) begin
                total++; if (valid_out !== 1'b1 || data_out !== exp_dat[i-2]) begin bad++; $display("FAIL alt_data[%0d] got=%b/%h exp=1/%h", i-2, valid_out, data_out, exp_dat[i-2]); end
            end else begin
                total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL alt_idle[%0d] got=%b exp=0", i, valid_out); end
            end
        end
    endtask

    task automatic test_single_source();
        do_reset();
        for (int k = 0; k < 5; k++) push0(6'(k + 5));
        #1;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) tick();
            total++; if (D0_pop !== (i < 5) || D1_pop !== 1'b0) begin bad++; $display("FAIL single_pop[%0d] got=%b%b exp=0%b", i, D1_pop, D0_pop, (i < 5)); end
            if (i == 7) begin
                req = 1'b1; idx = 1'b0; idle_in = 1'b1;
            end
        end
        tick();
        req = 1'b0;
        total++; if (valid_contador !== 1'b1 || contador_out !== 5'd5) begin bad++; $display("FAIL single_count got=%b/%0d exp=1/5", valid_contador, contador_out); end
    endtask

    task automatic test_backpressure();
        int emitted;
        emitted = 0;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            push0(6'(8'h0A + k));
            push1(6'(8'h1A + k));
        end
        #1;
        total++; if (D0_pop !== 1'b1 || D1_pop !== 1'b0) begin bad++; $display("FAIL bp_pop0 got=%b%b exp=01", D1_pop, D0_pop); end
        tick();
        total++; if (D1_pop !== 1'b1 || D0_pop !== 1'b0) begin bad++; $display("FAIL bp_pop1 got=%b%b exp=10", D1_pop, D0_pop); end
        @(negedge clk);
        sink_almost_full = 1'b1;
        #1;
        for (int i = 2; i < 6; i++) begin
            if (i > 2) tick();
            total++; if (D0_pop !== 1'b0 || D1_pop !== 1'b0) begin bad++; $display("FAIL bp_blocked[%0d] got=%b%b exp=00", i, D1_pop, D0_pop); end
            if (valid_out === 1'b1) emitted++;
        end
        total++; if (emitted !== 2) begin bad++; $display("FAIL bp_emitted got=%0d exp=2", emitted); end
        @(negedge clk);
        sink_almost_full = 1'b0;
        #1;
        total++; if (D0_pop !== 1'b1 || D1_pop !== 1'b0) begin bad++; $display("FAIL bp_resume got=%b%b exp=01", D1_pop, D0_pop); end
        tick();
        total++; if (D1_pop !== 1'b1 || D0_pop !== 1'b0) begin bad++; $display("FAIL bp_resume2 got=%b%b exp=10", D1_pop, D0_pop); end
    endtask

    task automatic test_counter_read();
        do_reset();
        push0(6'h03); push0(6'h04); push0(6'h05);
        push1(6'h22); push1(6'h23);
        repeat (7) @(negedge clk);
        req = 1'b1; idx = 1'b1; idle_in = 1'b1;
        tick();
        total++; if (valid_contador !== 1'b1 || contador_out !== 5'd2) begin bad++; $display("FAIL rd_d1 got=%b/%0d exp=1/2", valid_contador, contador_out); end
        idx = 1'b0;
        tick();
        total++; if (valid_contador !== 1'b1 || contador_out !== 5'd3) begin bad++; $display("FAIL rd_d0_b2b got=%b/%0d exp=1/3", valid_contador, contador_out); end
        idx = 1'b1; idle_in = 1'b0;
        tick();
        total++; if (valid_contador !== 1'b0 || contador_out !== 5'd3) begin bad++; $display("FAIL rd_busy got=%b/%0d exp=0/3", valid_contador, contador_out); end
        req = 1'b0;
        // wrap: 32 D0 words; a read coinciding with the 32nd increment sees 31
        do_reset();
        for (int k = 0; k < 32; k++) push0(6'(k));
        repeat (33) @(negedge clk);
        req = 1'b1; idx = 1'b0; idle_in = 1'b1;
        tick();
        total++; if (valid_contador !== 1'b1 || contador_out !== 5'd31) begin bad++; $display("FAIL rd_pre_wrap got=%b/%0d exp=1/31", valid_contador, contador_out); end
        tick();
        total++; if (valid_contador !== 1'b1 || contador_out !== 5'd0) begin bad++; $display("FAIL rd_wrap got=%b/%0d exp=1/0", valid_contador, contador_out); end
        req = 1'b0;
    endtask

    task automatic test_mid_reset();
        do_reset();
        push0(6'h31); push0(6'h32); push0(6'h33);
        repeat (3) @(negedge clk);
        #1;
        total++; if (valid_out !== 1'b1 || data_out !== 6'h32) begin bad++; $display("FAIL mr_pre got=%b/%h exp=1/32", valid_out, data_out); end
        reset = 1'b0;
        #1;
        total++; if (valid_out !== 1'b0 || data_out !== 6'h00) begin bad++; $display("FAIL mr_clear got=%b/%h exp=0/00", valid_out, data_out); end
        push0(6'h16);
        push1(6'h2B);
        @(negedge clk);
        reset = 1'b1;
        req = 1'b1; idx = 1'b0; idle_in = 1'b1;
        #1;
        total++; if (D0_pop !== 1'b1 || D1_pop !== 1'b0) begin bad++; $display("FAIL mr_first_grant got=%b%b exp=01", D1_pop, D0_pop); end
        tick();
        req = 1'b0;
        total++; if (valid_contador !== 1'b1 || contador_out !== 5'd0) begin bad++; $display("FAIL mr_count got=%b/%0d exp=1/0", valid_contador, contador_out); end
        total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL mr_lost_word got=%b/%h exp=0", valid_out, data_out); end
        tick();
        total++; if (valid_out !== 1'b1 || data_out !== 6'h16) begin bad++; $display("FAIL mr_post0 got=%b/%h exp=1/16", valid_out, data_out); end
        tick();
        total++; if (valid_out !== 1'b1 || data_out !== 6'h2B) begin bad++; $display("FAIL mr_post1 got=%b/%h exp=1/2b", valid_out, data_out); end
        tick();
        total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL mr_tail got=%b/%h exp=0", valid_out, data_out); end
    endtask

    task automatic test_random();
        logic [1:0] g;
        logic       ev;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 99) < 45) push0(6'($urandom_range(0, 63)));
            if ($urandom_range(0, 99) < 40) push1(6'($urandom_range(0, 63)));
            sink_almost_full = ($urandom_range(0, 99) < 25);
            req     = 1'($urandom_range(0, 1));
            idx     = 1'($urandom_range(0, 1));
            idle_in = ($urandom_range(0, 99) < 70);
            #1;
            g  = model_grant();
            ev = (inflight.size() > 0 && inflight[0].due == cyc);
            total++; if ({D1_pop, D0_pop} !== g) begin bad++; $display("FAIL rnd_pop[%0d] got=%b%b exp=%b", i, D1_pop, D0_pop, g); end
            total++; if (valid_out !== ev) begin bad++; $display("FAIL rnd_valid[%0d] got=%b exp=%b", i, valid_out, ev); end
            if (ev) begin
                total++; if (data_out !== inflight[0].w) begin bad++; $display("FAIL rnd_data[%0d] got=%h exp=%h", i, data_out, inflight[0].w); end
            end
            total++; if (valid_contador !== m_vc) begin bad++; $display("FAIL rnd_vcnt[%0d] got=%b exp=%b", i, valid_contador, m_vc); end
            total++; if (contador_out !== m_cont) begin bad++; $display("FAIL rnd_cnt[%0d] got=%0d exp=%0d", i, contador_out, m_cont); end
        end
        @(negedge clk);
        sink_almost_full = 1'b0;
        req = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        sink_almost_full = 1'b0;
        idle_in = 1'b0;
        req = 1'b0;
        idx = 1'b0;
        #1;
        reset = 1'b0;
        test_reset();
        test_alternation();
        test_single_source();
        test_backpressure();
        test_counter_read();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
